// File: rtl/gmac_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : gmac_tx_feeder
//  Description : Ping-pong frame buffer between a byte-wide user write port
//                and a GMAC transmit channel. Frames are stored whole, then
//                requested, granted and streamed out contiguously with a
//                fixed inter-frame gap. Oversize frames are dropped and
//                counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module gmac_tx_feeder #(
  parameter int MAX_LEN    = 1472,
  parameter int IFG_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  WrData,
  input  logic        WrEn,
  input  logic        WrLast,
  output logic        WrReady,
  output logic        ReqOut,
  input  logic        ReqConfirm,
  output logic        ValOut,
  output logic        SoFOut,
  output logic        EoFOut,
  output logic [7:0]  DataOut,
  output logic [15:0] DropCnt
);

  // Byte counter / length width: must represent the value MAX_LEN itself.
  localparam int CW = $clog2(MAX_LEN + 1);
  // Gap counter width: counts 0 .. IFG_CYCLES-1.
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [CW-1:0] c_MAX_LEN  = CW'(MAX_LEN);
  localparam logic [CW-1:0] c_ONE      = CW'(1);
  localparam logic [GW-1:0] c_GAP_LAST = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_SEND = 2'd2;
  localparam logic [1:0] c_ST_GAP  = 2'd3;

  // --------------------------------------------------------------------------
  // Storage: one byte array per slot, plus committed length and full flags.
  // --------------------------------------------------------------------------
  logic [7:0]    r_mem0 [0:MAX_LEN-1];
  logic [7:0]    r_mem1 [0:MAX_LEN-1];
  logic [CW-1:0] r_len0;
  logic [CW-1:0] r_len1;
  logic [1:0]    r_full;

  // Write side state
  logic [CW-1:0] r_wr_cnt;     // bytes stored so far in the frame being written
  logic          r_wr_slot;    // slot currently receiving bytes
  logic          r_dropping;   // frame exceeded MAX_LEN; discard through WrLast
  logic [15:0]   r_drop_cnt;

  // Read side state
  logic [1:0]    r_state;
  logic          r_rd_slot;    // slot currently owned by the read FSM
  logic [CW-1:0] r_rd_addr;    // next byte address to present
  logic [GW-1:0] r_gap_cnt;
  logic          r_val;
  logic          r_sof;
  logic          r_eof;
  logic [7:0]    r_data;

  // Write-side decode
  logic          w_wr_acc;
  logic          w_wr_over;
  logic          w_wr_store;
  logic          w_commit;
  logic          w_drop_end;
  logic [1:0]    w_set_mask;

  // Read-side decode
  logic [CW-1:0] w_rd_len;
  logic          w_rd_last;
  logic [7:0]    w_rd_byte;
  logic          w_free;
  logic [1:0]    w_free_mask;

  // A slot is writable only while it holds no committed frame.
  assign WrReady    = ~r_full[r_wr_slot];
  assign w_wr_acc   = WrEn & WrReady;
  // The byte that would land at index MAX_LEN (or anything after it) overflows.
  assign w_wr_over  = r_dropping | (r_wr_cnt == c_MAX_LEN);
  assign w_wr_store = w_wr_acc & ~w_wr_over;
  assign w_commit   = w_wr_store & WrLast;
  assign w_drop_end = w_wr_acc & w_wr_over & WrLast;
  assign w_set_mask = w_commit ? (r_wr_slot ? 2'b10 : 2'b01) : 2'b00;

  assign w_rd_len    = r_rd_slot ? r_len1 : r_len0;
  assign w_rd_last   = (r_rd_addr == (w_rd_len - c_ONE));
  assign w_rd_byte   = r_rd_slot ? r_mem1[r_rd_addr] : r_mem0[r_rd_addr];
  // The slot is released on the edge that ends the EoF cycle.
  assign w_free      = (r_state == c_ST_SEND) & r_eof;
  assign w_free_mask = w_free ? (r_rd_slot ? 2'b10 : 2'b01) : 2'b00;

  // Byte storage: accepted in-range bytes go to the current write slot.
  always_ff @(posedge CLK) begin
    if (w_wr_store) begin
      if (r_wr_slot) begin
        r_mem1[r_wr_cnt] <= WrData;
      end else begin
        r_mem0[r_wr_cnt] <= WrData;
      end
    end
  end

  // Write sequencing: address counter, overflow tracking, commit and drop count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_cnt   <= '0;
      r_wr_slot  <= 1'b0;
      r_dropping <= 1'b0;
      r_drop_cnt <= 16'h0000;
      r_len0     <= '0;
      r_len1     <= '0;
    end else if (w_wr_acc) begin
      if (WrLast) begin
        r_wr_cnt   <= '0;
        r_dropping <= 1'b0;
        if (w_drop_end) begin
          if (r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
          end
        end else begin
          // Commit: latch length, hand the slot to the reader, move on.
          if (r_wr_slot) begin
            r_len1 <= r_wr_cnt + c_ONE;
          end else begin
            r_len0 <= r_wr_cnt + c_ONE;
          end
          r_wr_slot <= ~r_wr_slot;
        end
      end else if (w_wr_over) begin
        r_dropping <= 1'b1;
      end else begin
        r_wr_cnt <= r_wr_cnt + c_ONE;
      end
    end
  end

  // Full flags: commit and free target different slots, so both apply at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_free_mask) | w_set_mask;
    end
  end

  // Read FSM: request, wait for grant, stream the frame, then hold the gap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= c_ST_IDLE;
      r_rd_slot <= 1'b0;
      r_rd_addr <= '0;
      r_gap_cnt <= '0;
      r_val     <= 1'b0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      // Output strobes are single-cycle unless a byte is issued below.
      r_val  <= 1'b0;
      r_sof  <= 1'b0;
      r_eof  <= 1'b0;
      r_data <= 8'h00;
      case (r_state)
        c_ST_IDLE: begin
          if (r_full[r_rd_slot]) begin
            r_state <= c_ST_REQ;
          end
        end
        c_ST_REQ: begin
          if (ReqConfirm) begin
            r_rd_addr <= '0;
            r_state   <= c_ST_SEND;
          end
        end
        c_ST_SEND: begin
          if (r_eof) begin
            // EoF cycle just ended: release the slot and start the gap.
            r_rd_slot <= ~r_rd_slot;
            r_gap_cnt <= '0;
            if (IFG_CYCLES == 0) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_state <= c_ST_GAP;
            end
          end else begin
            r_val  <= 1'b1;
            r_data <= w_rd_byte;
            r_sof  <= (r_rd_addr == '0);
            r_eof  <= w_rd_last;
            // Address parks on the last byte so it never indexes past the slot.
            if (!w_rd_last) begin
              r_rd_addr <= r_rd_addr + c_ONE;
            end
          end
        end
        c_ST_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign ReqOut  = (r_state == c_ST_REQ);
  assign ValOut  = r_val;
  assign SoFOut  = r_sof;
  assign EoFOut  = r_eof;
  assign DataOut = r_data;
  assign DropCnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gmac_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmac_tx_feeder
//  Description : Self-checking bench for gmac_tx_feeder. Expected output
//                bytes are queued as frames are written and compared as the
//                DUT presents them; scenario tasks add their own checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmac_tx_feeder;

  localparam int MAX_LEN    = 1472;
  localparam int IFG_CYCLES = 2;
  localparam int BOUND      = 4000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  WrData = 8'h00;
  logic        WrEn = 1'b0;
  logic        WrLast = 1'b0;
  logic        ReqConfirm = 1'b0;
  logic        WrReady;
  logic        ReqOut;
  logic        ValOut;
  logic        SoFOut;
  logic        EoFOut;
  logic [7:0]  DataOut;
  logic [15:0] DropCnt;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [9:0] sb[$];     // {sof, eof, data}
  logic [9:0] mon_exp;

  gmac_tx_feeder #(
    .MAX_LEN    (MAX_LEN),
    .IFG_CYCLES (IFG_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WrData     (WrData),
    .WrEn       (WrEn),
    .WrLast     (WrLast),
    .WrReady    (WrReady),
    .ReqOut     (ReqOut),
    .ReqConfirm (ReqConfirm),
    .ValOut     (ValOut),
    .SoFOut     (SoFOut),
    .EoFOut     (EoFOut),
    .DataOut    (DataOut),
    .DropCnt    (DropCnt)
  );

  always #5 CLK = ~CLK;

  // Scoreboard comparator: every presented byte must match the queue head.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        checks++;
        if (ValOut === 1'b1) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected: got sof=%b eof=%b data=%h, expected no byte", SoFOut, EoFOut, DataOut);
          end else begin
            mon_exp = sb.pop_front();
            if ({SoFOut, EoFOut, DataOut} !== mon_exp) begin
              errors++;
              $display("FAIL mon_byte: got sof=%b eof=%b data=%h, expected sof=%b eof=%b data=%h",
                       SoFOut, EoFOut, DataOut, mon_exp[9], mon_exp[8], mon_exp[7:0]);
            end
          end
        end else if (ValOut !== 1'b0 || SoFOut !== 1'b0 || EoFOut !== 1'b0 || DataOut !== 8'h00) begin
          errors++;
          $display("FAIL mon_idle: got val=%b sof=%b eof=%b data=%h, expected all zero", ValOut, SoFOut, EoFOut, DataOut);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Writes a frame of len bytes (base, base+1, ...) and queues it if it fits.
  task automatic write_frame(input int len, input logic [7:0] base, output int stalls);
    int n;
    stalls = 0;
    if (len <= MAX_LEN) begin
      for (int i = 0; i < len; i++) sb.push_back({(i == 0), (i == len - 1), 8'(base + i)});
    end
    @(posedge CLK); #1;
    for (int i = 0; i < len; i++) begin
      WrEn = 1'b1; WrData = 8'(base + i); WrLast = (i == len - 1);
      n = 0;
      @(negedge CLK);
      while (WrReady !== 1'b1 && n < BOUND) begin n++; stalls++; @(negedge CLK); end
      if (WrReady !== 1'b1) begin
        checks++; errors++;
        $display("FAIL write_timeout: WrReady=%b at byte %0d, expected 1", WrReady, i);
        WrEn = 1'b0; WrLast = 1'b0;
        return;
      end
      @(posedge CLK); #1;
    end
    WrEn = 1'b0; WrLast = 1'b0;
  endtask

  // Waits for ReqOut, then grants after dly further cycles.
  task automatic grant(input int dly);
    int n = 0;
    @(negedge CLK);
    while (ReqOut !== 1'b1 && n < BOUND) begin n++; @(negedge CLK); end
    checks++;
    if (ReqOut !== 1'b1) begin
      errors++; $display("FAIL grant_req: ReqOut=%b after %0d cycles, expected 1", ReqOut, n);
      return;
    end
    repeat (dly) @(negedge CLK);
    ReqConfirm = 1'b1; @(posedge CLK); #1; ReqConfirm = 1'b0;
  endtask

  task automatic wait_eof();
    int n = 0;
    @(negedge CLK);
    while (EoFOut !== 1'b1 && n < BOUND) begin n++; @(negedge CLK); end
    checks++;
    if (EoFOut !== 1'b1) begin errors++; $display("FAIL wait_eof: EoFOut=%b after %0d cycles, expected 1", EoFOut, n); end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    @(negedge CLK);
    while ((sb.size() != 0 || ValOut === 1'b1) && n < BOUND) begin n++; @(negedge CLK); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL %s_drain: %0d bytes outstanding, expected 0", tag, sb.size()); end
    repeat (6) @(negedge CLK);
    checks++;
    if (ReqOut !== 1'b0) begin errors++; $display("FAIL %s_extra_req: ReqOut=%b, expected 0", tag, ReqOut); end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checks++; if (WrReady !== 1'b1) begin errors++; $display("FAIL rst_wrready: got %b expected 1", WrReady); end
    checks++; if (ReqOut !== 1'b0) begin errors++; $display("FAIL rst_reqout: got %b expected 0", ReqOut); end
    checks++; if ({ValOut, SoFOut, EoFOut} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b expected 000", {ValOut, SoFOut, EoFOut}); end
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", DataOut); end
    checks++; if (DropCnt !== 16'h0000) begin errors++; $display("FAIL rst_dropcnt: got %h expected 0000", DropCnt); end
    @(posedge CLK); #1; RST = 1'b0;
  endtask

  task automatic test_basic();
    int s;
    int n = 0;
    logic [10:0] exp;
    write_frame(4, 8'hA1, s);
    @(negedge CLK);
    while (ReqOut !== 1'b1 && n < BOUND) begin n++; @(negedge CLK); end
    checks++; if (ReqOut !== 1'b1) begin errors++; $display("FAIL basic_req: got %b expected 1", ReqOut); end
    repeat (3) begin
      @(negedge CLK);
      checks++; if (ReqOut !== 1'b1) begin errors++; $display("FAIL basic_req_hold: got %b expected 1", ReqOut); end
    end
    ReqConfirm = 1'b1; @(posedge CLK); #1; ReqConfirm = 1'b0;
    @(negedge CLK);
    checks++; if ({ValOut, ReqOut} !== 2'b00) begin errors++; $display("FAIL basic_latency: val,req=%b expected 00", {ValOut, ReqOut}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      exp = {1'b1, (i == 0), (i == 3), 8'(8'hA1 + i)};
      checks++;
      if ({ValOut, SoFOut, EoFOut, DataOut} !== exp) begin
        errors++; $display("FAIL basic_byte%0d: got %b expected %b", i, {ValOut, SoFOut, EoFOut, DataOut}, exp);
      end
    end
    repeat (IFG_CYCLES) begin
      @(negedge CLK);
      checks++; if ({ValOut, ReqOut} !== 2'b00) begin errors++; $display("FAIL basic_ifg: val,req=%b expected 00", {ValOut, ReqOut}); end
    end
    wait_drain("basic");
  endtask

  task automatic test_one_byte();
    int s;
    int n = 0;
    write_frame(1, 8'h5A, s);
    grant(0);
    @(negedge CLK);
    while (ValOut !== 1'b1 && n < BOUND) begin n++; @(negedge CLK); end
    checks++;
    if ({ValOut, SoFOut, EoFOut, DataOut} !== {3'b111, 8'h5A}) begin
      errors++; $display("FAIL one_byte: got %b expected %b", {ValOut, SoFOut, EoFOut, DataOut}, {3'b111, 8'h5A});
    end
    @(negedge CLK);
    checks++; if (ValOut !== 1'b0) begin errors++; $display("FAIL one_byte_single: ValOut=%b expected 0", ValOut); end
    wait_drain("one_byte");
  endtask

  task automatic test_oversize();
    int s;
    write_frame(MAX_LEN + 1, 8'h00, s);
    repeat (4) @(negedge CLK);
    checks++; if (ReqOut !== 1'b0) begin errors++; $display("FAIL oversize_no_req: ReqOut=%b expected 0", ReqOut); end
    checks++; if (DropCnt !== 16'd1) begin errors++; $display("FAIL oversize_dropcnt: got %0d expected 1", DropCnt); end
    write_frame(10, 8'h80, s);
    grant(1);
    wait_drain("oversize");
    checks++; if (DropCnt !== 16'd1) begin errors++; $display("FAIL oversize_dropcnt_after: got %0d expected 1", DropCnt); end
  endtask

  task automatic test_back_to_back();
    int s;
    int s3 = 0;
    write_frame(5, 8'h10, s);
    write_frame(5, 8'h20, s);
    fork
      write_frame(5, 8'h30, s3);
      begin
        repeat (8) @(negedge CLK);
        checks++; if (WrReady !== 1'b0) begin errors++; $display("FAIL b2b_wrready_low: got %b expected 0", WrReady); end
        checks++; if (ReqOut !== 1'b1) begin errors++; $display("FAIL b2b_req_held: got %b expected 1", ReqOut); end
        grant(0);
        wait_eof();
        checks++; if (WrReady !== 1'b0) begin errors++; $display("FAIL b2b_wrready_eof: got %b expected 0", WrReady); end
        @(negedge CLK);
        checks++; if (WrReady !== 1'b1) begin errors++; $display("FAIL b2b_wrready_free: got %b expected 1", WrReady); end
        grant(2);
        grant(0);
      end
    join
    checks++; if (s3 < 8) begin errors++; $display("FAIL b2b_stall: third frame stalled %0d cycles, expected at least 8", s3); end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_send();
    int s;
    int n = 0;
    int cnt = 0;
    write_frame(6, 8'h60, s);
    grant(0);
    while (cnt < 3 && n < BOUND) begin
      @(negedge CLK);
      n++;
      if (ValOut === 1'b1) cnt++;
    end
    checks++; if (cnt != 3) begin errors++; $display("FAIL rstmid_bytes: saw %0d bytes expected 3", cnt); end
    RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    sb.delete();
    @(negedge CLK);
    checks++; if ({ValOut, SoFOut, EoFOut, ReqOut} !== 4'b0000) begin errors++; $display("FAIL rstmid_outputs: val,sof,eof,req=%b expected 0000", {ValOut, SoFOut, EoFOut, ReqOut}); end
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", DataOut); end
    checks++; if (WrReady !== 1'b1) begin errors++; $display("FAIL rstmid_wrready: got %b expected 1", WrReady); end
    checks++; if (DropCnt !== 16'd0) begin errors++; $display("FAIL rstmid_dropcnt: got %0d expected 0", DropCnt); end
    write_frame(3, 8'h70, s);
    grant(0);
    wait_drain("rstmid");
  endtask

  task automatic test_same_cycle();
    int s;
    write_frame(4, 8'hC0, s);
    sb.push_back({2'b10, 8'hB0});
    sb.push_back({2'b00, 8'hB1});
    sb.push_back({2'b01, 8'hB2});
    WrEn = 1'b1; WrLast = 1'b0; WrData = 8'hB0;
    @(posedge CLK); #1; WrData = 8'hB1;
    @(posedge CLK); #1; WrEn = 1'b0;
    grant(0);
    wait_eof();
    checks++; if (WrReady !== 1'b1) begin errors++; $display("FAIL same_wrready_pre: got %b expected 1", WrReady); end
    WrEn = 1'b1; WrData = 8'hB2; WrLast = 1'b1;
    @(posedge CLK); #1; WrEn = 1'b0; WrLast = 1'b0;
    @(negedge CLK);
    checks++; if (WrReady !== 1'b1) begin errors++; $display("FAIL same_wrready_post: got %b expected 1", WrReady); end
    checks++; if ({ValOut, ReqOut} !== 2'b00) begin errors++; $display("FAIL same_gap: val,req=%b expected 00", {ValOut, ReqOut}); end
    write_frame(2, 8'hD0, s);
    grant(0);
    grant(0);
    wait_drain("same");
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_basic();
    test_one_byte();
    test_oversize();
    test_back_to_back();
    test_reset_mid_send();
    test_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gmac_tx_feeder.md
GMAC_TX_FEEDER -- requirements
Module: gmac_tx_feeder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1472, maximum frame length in bytes.
REQ-002 SHALL have parameter IFG_CYCLES, default 2, idle cycles after each EoF.
REQ-003 SHALL have port CLK  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have port WrData  in  8  user byte.
REQ-006 SHALL have port WrEn  in  1  byte strobe; byte accepted when WrEn & WrReady.
REQ-007 SHALL have port WrLast  in  1  marks the accepted byte as the last of the frame.
REQ-008 SHALL have port WrReady  out  1  high when a buffer slot is available for writing.
REQ-009 SHALL have port ReqOut  out  1  transmit request to the GMAC channel input.
REQ-010 SHALL have port ReqConfirm  in  1  GMAC grant for this channel.
REQ-011 SHALL have port ValOut  out  1  byte valid to the GMAC.
REQ-012 SHALL have port SoFOut  out  1  first byte of frame.
REQ-013 SHALL have port EoFOut  out  1  last byte of frame.
REQ-014 SHALL have port DataOut  out  8  frame byte.
REQ-015 SHALL have port DropCnt  out  16  count of dropped oversize frames, saturating.

Function
REQ-016 SHALL hold two slots (ping-pong), each MAX_LEN bytes plus a committed length and a full flag.
REQ-017 SHALL write accepted bytes sequentially into the current write slot from address 0.
REQ-018 SHALL hold WrReady high exactly when the current write slot is not full.
REQ-019 SHALL, on an accepted byte with WrLast=1, set the slot full, latch its length, and toggle the write slot, provided length <= MAX_LEN.
REQ-020 SHALL discard the frame when byte count exceeds MAX_LEN: no storage, further bytes dropped through WrLast, slot not committed, DropCnt +1 (holds at 16'hFFFF).
REQ-021 SHALL use a read FSM with states IDLE, REQ, SEND, GAP.
REQ-022 IDLE: on read slot full -> REQ next cycle.
REQ-023 REQ: ReqOut=1 in every REQ cycle; ReqConfirm sampled high -> SEND; otherwise stays in REQ indefinitely.
REQ-024 SEND: ReqOut=0; if ReqConfirm is sampled at edge k, the first byte SHALL be presented with ValOut=SoFOut=1 in the cycle after edge k+1 (latency 2).
REQ-025 SEND: bytes SHALL be contiguous, one per cycle, with ValOut=1 and no gaps, in write order.
REQ-026 SHALL assert EoFOut with the final byte; a 1-byte frame SHALL assert SoFOut and EoFOut together.
REQ-027 SHALL clear the read slot's full flag, toggle the read slot, and enter GAP in the cycle after EoF.
REQ-028 GAP: ValOut=0 and ReqOut=0 for IFG_CYCLES cycles, then IDLE.
REQ-029 SHALL hold SoFOut, EoFOut, and ValOut at 0 and DataOut at 8'h00 whenever no byte is presented.
REQ-030 SHALL transmit frames strictly in commit order.
REQ-031 SHALL apply both a same-cycle write commit and a read free to their respective slots.
REQ-032 SHALL, when a write frame is in progress and both slots are full, hold WrReady=0 and stall without data loss.

Reset
REQ-033 SHALL, on RST=1 at an edge: FSM -> IDLE; both slots empty; slot pointers -> 0; any partial or in-flight frame discarded; DropCnt=0.
REQ-034 SHALL, on RST=1 at an edge: ReqOut, ValOut, SoFOut, EoFOut = 0; DataOut=8'h00; WrReady=1 from the first cycle after reset.
REQ-035 SHALL, when RST is asserted mid-SEND, drop ValOut in the next cycle with no EoFOut emitted.

Verification
REQ-036 SHALL test: write 4 bytes A1..A4, WrLast on A4, ReqConfirm 3 cycles after ReqOut -> SoF+A1, A2, A3, EoF+A4 contiguous at latency 2, then 2 idle cycles.
REQ-037 SHALL test: 1-byte frame 5A -> a single ValOut cycle with SoFOut=EoFOut=1, DataOut=5A.
REQ-038 SHALL test: MAX_LEN+1 byte frame followed by a 10-byte frame -> only the 10-byte frame is sent; DropCnt=1.
REQ-039 SHALL test: three back-to-back frames with ReqConfirm withheld -> WrReady=0 during the third frame until the first frame's EoF+1; all three frames are sent in order, intact.
REQ-040 SHALL test: RST pulse during the 3rd byte of SEND -> outputs 0 next cycle; a new frame afterwards is sent correctly.
REQ-041 SHALL test: commit and free in the same cycle -> both slots' states are correct and no frame is lost or duplicated.
